// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_timer
//  Description : Raster scan generator for a 640x480@60 VGA display.
//                Divides the system clock down to the pixel rate, walks
//                xCount/yCount across the full line/frame (including blanking),
//                and decodes active-low hsync/vsync, video_on, a one-clock
//                frame_tick at the start of vertical blank, and the game-tick
//                strobe `update`. The strobe is one scan line wide, and it is
//                issued once every FRAMES_PER_UPDATE frames unless pause is
//                set when the frame ticks.
//
//  Ports       : clk        in   system clock
//                rst        in   synchronous active-high reset
//                pause      in   1 = suppress update strobes (scan continues)
//                xCount     out  current pixel column, 0..H_TOTAL-1
//                yCount     out  current line, 0..V_TOTAL-1
//                hsync      out  horizontal sync, active-low
//                vsync      out  vertical sync, active-low
//                video_on   out  1 inside the visible window
//                frame_tick out  one-clock pulse on entry to (0, V_VISIBLE)
//                update     out  game tick, high for the whole line V_VISIBLE
//
//  Revision    : 1.0  initial release
// ============================================================================
module vga_scan_timer #(
    parameter int CLK_DIV           = 2,
    parameter int H_VISIBLE         = 640,
    parameter int H_FRONT           = 16,
    parameter int H_SYNC            = 96,
    parameter int H_BACK            = 48,
    parameter int V_VISIBLE         = 480,
    parameter int V_FRONT           = 10,
    parameter int V_SYNC            = 2,
    parameter int V_BACK            = 33,
    parameter int FRAMES_PER_UPDATE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    output logic [9:0] xCount,
    output logic [9:0] yCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic       update
);

    // ------------------------------------------------------------------
    // Derived timing constants (all 10 bits wide to match the counters)
    // ------------------------------------------------------------------
    localparam int c_H_TOTAL_I = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL_I = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL_I - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL_I - 1);
    localparam logic [9:0] c_H_VISIBLE  = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VISIBLE  = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Counter widths; a width of 1 is kept for the degenerate divide/frame
    // ratios of 1 so the registers still exist and simply stay at 0.
    localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_FCNT_W = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FRAMES_PER_UPDATE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0]  r_div;     // clocks elapsed within the current pixel
    logic [c_FCNT_W-1:0] r_fcnt;    // frames elapsed within the current game tick

    // ------------------------------------------------------------------
    // Next-position logic
    // ------------------------------------------------------------------
    logic       w_pixTick;      // last clock of the current pixel period
    logic [9:0] w_nextX;
    logic [9:0] w_nextY;
    logic       w_frameStart;   // this edge enters (0, V_VISIBLE)
    logic       w_hsyncN;
    logic       w_vsyncN;
    logic       w_videoOn;
    logic       w_updateNext;

    always_comb begin
        w_pixTick = (r_div >= c_DIV_LAST);
        w_nextX   = xCount;
        w_nextY   = yCount;

        if (w_pixTick) begin
            if (xCount >= c_H_LAST) begin
                // End of line (or an unreachable out-of-range column).
                w_nextX = 10'd0;
                if (yCount >= c_V_LAST) begin
                    w_nextY = 10'd0;
                end else begin
                    w_nextY = yCount + 10'd1;
                end
            end else begin
                w_nextX = xCount + 10'd1;
                // An out-of-range line cannot be reached, but if it ever is
                // the scan recovers on the next pixel rather than running on.
                if (yCount > c_V_LAST) begin
                    w_nextY = 10'd0;
                end
            end
        end

        // Only a pixel-tick edge can land on a new position, so this is true
        // on exactly one edge per frame regardless of CLK_DIV.
        w_frameStart = w_pixTick && (w_nextX == 10'd0) && (w_nextY == c_V_VISIBLE);
    end

    // ------------------------------------------------------------------
    // Decoded outputs, computed from the next position so that the
    // registered outputs line up with the registered counters.
    // ------------------------------------------------------------------
    always_comb begin
        w_hsyncN  = !((w_nextX >= c_HS_START) && (w_nextX < c_HS_END));
        w_vsyncN  = !((w_nextY >= c_VS_START) && (w_nextY < c_VS_END));
        w_videoOn = (w_nextX < c_H_VISIBLE) && (w_nextY < c_V_VISIBLE);

        // The strobe decision is taken once, on the edge that enters the
        // first blanking line, and then held for that whole line so that a
        // later change of pause cannot cut it short.
        w_updateNext = 1'b0;
        if (w_nextY == c_V_VISIBLE) begin
            if (w_frameStart) begin
                w_updateNext = (r_fcnt == '0) && !pause;
            end else begin
                w_updateNext = update;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pixTick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan position and decoded timing outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            xCount     <= 10'd0;
            yCount     <= 10'd0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            frame_tick <= 1'b0;
            update     <= 1'b0;
        end else begin
            xCount     <= w_nextX;
            yCount     <= w_nextY;
            hsync      <= w_hsyncN;
            vsync      <= w_vsyncN;
            video_on   <= w_videoOn;
            frame_tick <= w_frameStart;
            update     <= w_updateNext;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter: every frame is counted, paused or not, so pausing
    // never shifts the game-tick schedule.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
        end else if (w_frameStart) begin
            if (r_fcnt >= c_FCNT_LAST) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + c_FCNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_timer
//  Description : Self-checking bench for vga_scan_timer using a reduced
//                raster (25 x 17 positions, CLK_DIV=2, FRAMES_PER_UPDATE=3)
//                so that many frames fit in a short run. A closed-form model
//                of the scan position (from the edge count since reset)
//                feeds a scoreboard queue every clock; a table of
//                hand-derived checkpoints and a few directed sequences
//                (pause, mid-pulse reset) cover the corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scan_timer;

    localparam int CD  = 2;
    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HS  = 4;
    localparam int HB  = 3;
    localparam int VV  = 10;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int FPU = 3;
    localparam int HT  = HV + HF + HS + HB;   // 25
    localparam int VT  = VV + VF + VS + VB;   // 17

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
        logic       upd;
    } outs_t;

    typedef struct {
        int    k;      // edges since reset release at which to compare
        outs_t exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       pause;
    logic [9:0] xCount;
    logic [9:0] yCount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_tick;
    logic       update;

    vga_scan_timer #(
        .CLK_DIV           (CD),
        .H_VISIBLE         (HV),
        .H_FRONT           (HF),
        .H_SYNC            (HS),
        .H_BACK            (HB),
        .V_VISIBLE         (VV),
        .V_FRONT           (VF),
        .V_SYNC            (VS),
        .V_BACK            (VB),
        .FRAMES_PER_UPDATE (FPU)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .xCount     (xCount),
        .yCount     (yCount),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .update     (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t cur;
    assign cur = {xCount, yCount, hsync, vsync, video_on, frame_tick, update};

    outs_t sbq[$];
    vec_t  vecs[16];

    int  nCmp    = 0;
    int  nErr    = 0;
    int  k       = 0;   // non-reset edges since last reset
    int  ticks   = 0;   // frame ticks since last reset (model)
    bit  updLine = 0;   // model: this frame's blanking line carries update
    int  updHigh = 0;   // DUT clocks with update=1
    int  ftCount = 0;   // DUT frame_tick pulses

    function automatic outs_t mk(int x, int y, bit hs, bit vs, bit von, bit ft, bit upd);
        outs_t o;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.hs  = hs;
        o.vs  = vs;
        o.von = von;
        o.ft  = ft;
        o.upd = upd;
        return o;
    endfunction

    task automatic chkOuts(input string name, input outs_t got, input outs_t exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s k=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b ft=%b upd=%b, need x=%0d y=%0d hs=%b vs=%b von=%b ft=%b upd=%b",
                     name, k, got.x, got.y, got.hs, got.vs, got.von, got.ft, got.upd,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ft, exp.upd);
        end
    endtask

    task automatic chkInt(input string name, input int got, input int exp);
        nCmp++;
        if (got != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    // One clock: predict the post-edge outputs from the current inputs,
    // queue the prediction, clock, then compare what the DUT produced.
    task automatic step();
        outs_t e;
        outs_t g;
        int    p;
        int    x;
        int    y;
        if (rst) begin
            e       = mk(0, 0, 1, 1, 0, 0, 0);
            k       = 0;
            ticks   = 0;
            updLine = 0;
        end else begin
            k++;
            p = k / CD;
            x = p % HT;
            y = (p / HT) % VT;
            e = mk(x, y,
                   !(x >= HV + HF && x < HV + HF + HS),
                   !(y >= VV + VF && y < VV + VF + VS),
                   (x < HV) && (y < VV),
                   (x == 0) && (y == VV) && (k % CD == 0),
                   1'b0);
            if (e.ft) begin
                updLine = ((ticks % FPU) == 0) && !pause;
                ticks++;
            end
            e.upd = (y == VV) && updLine;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = cur;
        chkOuts("stream", g, sbq.pop_front());
        if (update)     updHigh++;
        if (frame_tick) ftCount++;
    endtask

    task automatic runTo(input int target);
        while (k < target) step();
    endtask

    initial begin
        // Hand-derived checkpoints for the first frame after reset release.
        vecs[0]  = '{1,   mk(0,  0,  1, 1, 1, 0, 0)};
        vecs[1]  = '{2,   mk(1,  0,  1, 1, 1, 0, 0)};
        vecs[2]  = '{32,  mk(16, 0,  1, 1, 0, 0, 0)};   // visible ends
        vecs[3]  = '{36,  mk(18, 0,  0, 1, 0, 0, 0)};   // hsync starts
        vecs[4]  = '{43,  mk(21, 0,  0, 1, 0, 0, 0)};   // last hsync pixel
        vecs[5]  = '{44,  mk(22, 0,  1, 1, 0, 0, 0)};
        vecs[6]  = '{49,  mk(24, 0,  1, 1, 0, 0, 0)};   // last column
        vecs[7]  = '{50,  mk(0,  1,  1, 1, 1, 0, 0)};   // line wrap
        vecs[8]  = '{500, mk(0,  10, 1, 1, 0, 1, 1)};   // frame_tick + update rise
        vecs[9]  = '{501, mk(0,  10, 1, 1, 0, 0, 1)};
        vecs[10] = '{549, mk(24, 10, 1, 1, 0, 0, 1)};   // last clock of pulse
        vecs[11] = '{550, mk(0,  11, 1, 1, 0, 0, 0)};
        vecs[12] = '{600, mk(0,  12, 1, 0, 0, 0, 0)};   // vsync starts
        vecs[13] = '{700, mk(0,  14, 1, 1, 0, 0, 0)};   // vsync ended
        vecs[14] = '{849, mk(24, 16, 1, 1, 0, 0, 0)};   // last position
        vecs[15] = '{850, mk(0,  0,  1, 1, 1, 0, 0)};   // frame wrap

        rst   = 1'b1;
        pause = 1'b0;
        repeat (3) step();
        chkOuts("reset", cur, mk(0, 0, 1, 1, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            runTo(vecs[i].k);
            chkOuts($sformatf("vec%0d", i), cur, vecs[i].exp);
        end

        // Seven frames unpaused: pulses on frames 0, 3, 6 only.
        runTo(7 * 850);
        chkInt("updClocks7", updHigh, 3 * HT * CD);
        chkInt("ticks7", ftCount, 7);

        // Pause held across frame 9's tick (fcnt==0), released mid-line.
        pause = 1'b1;
        runTo(9 * 850 + 500);
        pause = 1'b0;
        runTo(9 * 850 + 510);
        chkOuts("pausedTick", cur, mk(5, 10, 1, 1, 0, 0, 0));
        runTo(10 * 850);
        chkInt("pausedFrame", updHigh, 3 * HT * CD);

        // Schedule resumes at frame 12.
        runTo(12 * 850 + 501);
        chkOuts("resumeUpd", cur, mk(0, 10, 1, 1, 0, 0, 1));
        runTo(12 * 850 + 524);
        chkOuts("preRst", cur, mk(12, 10, 1, 1, 0, 0, 1));

        // Reset in the middle of the pulse.
        rst = 1'b1;
        step();
        chkOuts("midRst", cur, mk(0, 0, 1, 1, 0, 0, 0));
        rst = 1'b0;

        runTo(500);
        chkOuts("postRstUpd", cur, mk(0, 10, 1, 1, 0, 1, 1));
        // Raising pause mid-pulse must not truncate it.
        pause = 1'b1;
        runTo(549);
        chkOuts("noTruncate", cur, mk(24, 10, 1, 1, 0, 0, 1));
        runTo(550);
        chkOuts("pulseEnd", cur, mk(0, 11, 1, 1, 0, 0, 0));
        pause = 1'b0;

        chkInt("updTotal", updHigh, 3 * HT * CD + 25 + HT * CD);
        chkInt("ticksTotal", ftCount, 14);
        chkInt("sbEmpty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
